// File: rtl/trigger_gen_pkg.sv
// Shared types and default sizing for the trigger generator.
package trigger_gen_pkg;

  localparam int CW      = 24;  // period/high/phase counter width
  localparam int BW      = 8;   // burst-count width
  localparam int LED_DIV = 50;  // channel-0 rising edges per LED toggle

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2
  } chan_state_e;

  // Channel configuration layout at the default widths.
  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic [CW-1:0] phase;
    logic [BW-1:0] burst;
  } trig_cfg_t;

  // Channel-select width: at least one bit even for a single channel.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trigger_chan.sv
// One trigger channel: shadow/active config, IDLE/DELAY/RUN FSM,
// period/phase/pulse counters and registered q/busy/done.
module trigger_chan #(
  parameter int CW = trigger_gen_pkg::CW,
  parameter int BW = trigger_gen_pkg::BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] high,
  input  logic [CW-1:0] phase,
  input  logic [BW-1:0] burst,
  input  logic          start,
  input  logic          stop,
  output logic          q,
  output logic          busy,
  output logic          done
);
  import trigger_gen_pkg::*;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic [CW-1:0] phase;
    logic [BW-1:0] burst;
  } cfg_t;

  cfg_t          shd, act, act_n;
  chan_state_e   state, st_n;
  logic [CW-1:0] cnt, cnt_n, dcnt, dcnt_n, peff, peff_n;
  logic [BW-1:0] pcnt, pcnt_n;
  logic          last_n;

  function automatic logic [CW-1:0] eff_period(input logic [CW-1:0] p);
    return (p == '0) ? CW'(1) : p;
  endfunction

  // Next-state decode; q and done are computed from the next state so the
  // registered outputs line up with the cycle the counters describe.
  always_comb begin
    st_n   = state;
    cnt_n  = cnt;
    dcnt_n = dcnt;
    pcnt_n = pcnt;
    act_n  = act;
    peff   = eff_period(act.period);
    if (stop) begin
      st_n   = IDLE;
      cnt_n  = '0;
      dcnt_n = '0;
      pcnt_n = '0;
    end else if (start) begin
      act_n  = shd;
      cnt_n  = '0;
      dcnt_n = '0;
      pcnt_n = '0;
      st_n   = (shd.phase != '0) ? DELAY : RUN;
    end else begin
      case (state)
        DELAY: begin
          if (dcnt == act.phase - CW'(1)) begin
            st_n  = RUN;
            cnt_n = '0;
          end else begin
            dcnt_n = dcnt + CW'(1);
          end
        end
        RUN: begin
          if (cnt == peff - CW'(1)) begin
            cnt_n = '0;
            // >= so a burst shortened by a reload still terminates
            if (act.burst != '0 && pcnt >= act.burst - BW'(1)) begin
              st_n   = IDLE;
              pcnt_n = '0;
            end else begin
              act_n = shd;  // config changes take effect only on a wrap
              if (pcnt != '1) pcnt_n = pcnt + BW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
    peff_n = eff_period(act_n.period);
    last_n = (st_n == RUN) && (cnt_n == peff_n - CW'(1)) &&
             (act_n.burst != '0) && (pcnt_n >= act_n.burst - BW'(1));
  end

  // Channel state, config registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      pcnt  <= '0;
      shd   <= '0;
      act   <= '0;
      q     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (wr) shd <= '{period: period, high: high, phase: phase, burst: burst};
      state <= st_n;
      cnt   <= cnt_n;
      dcnt  <= dcnt_n;
      pcnt  <= pcnt_n;
      act   <= act_n;
      q     <= (st_n == RUN) && (cnt_n < act_n.high);
      busy  <= (st_n != IDLE);
      done  <= last_n;
    end
  end

endmodule

// File: rtl/trigger_gen.sv
// Multi-channel periodic trigger generator: config write decode, one
// trigger_chan per channel, and a heartbeat LED driven by channel 0.
module trigger_gen #(
  parameter  int NCH     = 4,
  parameter  int CW      = trigger_gen_pkg::CW,
  parameter  int BW      = trigger_gen_pkg::BW,
  parameter  int LED_DIV = trigger_gen_pkg::LED_DIV,
  localparam int CHW     = trigger_gen_pkg::chw(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_high,
  input  logic [CW-1:0]  cfg_phase,
  input  logic [BW-1:0]  cfg_burst,
  input  logic [NCH-1:0] start,
  input  logic [NCH-1:0] stop,
  output logic [NCH-1:0] q,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] done,
  output logic           led
);
  import trigger_gen_pkg::*;

  localparam int LW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

  logic [NCH-1:0] wr_sel;
  logic [LW-1:0]  led_cnt;
  logic           q0_d;

  // Write decode; a select at or beyond NCH matches no channel.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++)
      wr_sel[i] = cfg_wr && (int'(cfg_ch) == i);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    trigger_chan #(.CW(CW), .BW(BW)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .wr     (wr_sel[i]),
      .period (cfg_period),
      .high   (cfg_high),
      .phase  (cfg_phase),
      .burst  (cfg_burst),
      .start  (start[i]),
      .stop   (stop[i]),
      .q      (q[i]),
      .busy   (busy[i]),
      .done   (done[i])
    );
  end

  // Heartbeat: count channel-0 rising edges and toggle on each wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_cnt <= '0;
      q0_d    <= 1'b0;
      led     <= 1'b0;
    end else begin
      q0_d <= q[0];
      if (q[0] && !q0_d) begin
        if (led_cnt == LW'(LED_DIV - 1)) begin
          led_cnt <= '0;
          led     <= ~led;
        end else begin
          led_cnt <= led_cnt + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trigger_gen.sv
// Bench for trigger_gen: directed table checks, corner-case sequences and
// random traffic compared every cycle against a time-based channel model.
module tb_trigger_gen;
  localparam int NCH = 5, CW = 24, BW = 8, LED_DIV = 2;

  logic           clk = 1'b0;
  logic           rst, cfg_wr;
  logic [2:0]     cfg_ch;
  logic [CW-1:0]  cfg_period, cfg_high, cfg_phase;
  logic [BW-1:0]  cfg_burst;
  logic [NCH-1:0] start, stop, q, busy, done;
  logic           led;

  trigger_gen #(.NCH(NCH), .CW(CW), .BW(BW), .LED_DIV(LED_DIV)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .q(q), .busy(busy), .done(done), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: each running channel tracks its age within the current period
  // (negative while waiting out the phase) and completed-period count.
  bit             m_run [NCH];
  int             m_age [NCH], m_cnt [NCH];
  int             a_per [NCH], a_hi [NCH], a_ph [NCH], a_bu [NCH];
  int             s_per [NCH], s_hi [NCH], s_ph [NCH], s_bu [NCH];
  logic [NCH-1:0] e_q, e_busy, e_done;
  logic           e_led, m_q0p;
  int             m_lcnt;

  logic [NCH-1:0] hq [64], hb [64], hd [64];
  logic           hl [64];

  typedef struct { int ch; int k; logic q; logic busy; logic done; } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic load(input int c);
    a_per[c] = s_per[c]; a_hi[c] = s_hi[c]; a_ph[c] = s_ph[c]; a_bu[c] = s_bu[c];
  endtask

  task automatic model_edge();
    int pe;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = 0; m_age[c] = 0; m_cnt[c] = 0;
        a_per[c] = 0; a_hi[c] = 0; a_ph[c] = 0; a_bu[c] = 0;
        s_per[c] = 0; s_hi[c] = 0; s_ph[c] = 0; s_bu[c] = 0;
      end
      e_q = '0; e_busy = '0; e_done = '0; e_led = 1'b0; m_q0p = 1'b0; m_lcnt = 0;
      return;
    end
    if (e_q[0] && !m_q0p) begin
      m_lcnt++;
      if (m_lcnt == LED_DIV) begin m_lcnt = 0; e_led = ~e_led; end
    end
    m_q0p = e_q[0];
    for (int c = 0; c < NCH; c++) begin
      if (stop[c]) m_run[c] = 0;
      else if (start[c]) begin
        load(c); m_age[c] = -a_ph[c]; m_cnt[c] = 0; m_run[c] = 1;
      end else if (m_run[c]) begin
        pe = (a_per[c] > 0) ? a_per[c] : 1;
        if (m_age[c] == pe - 1) begin
          m_cnt[c]++;
          if (a_bu[c] > 0 && m_cnt[c] >= a_bu[c]) m_run[c] = 0;
          else begin m_age[c] = 0; load(c); end
        end else m_age[c]++;
      end
      pe = (a_per[c] > 0) ? a_per[c] : 1;
      e_busy[c] = m_run[c];
      e_q[c]    = m_run[c] && m_age[c] >= 0 && m_age[c] < a_hi[c];
      e_done[c] = m_run[c] && m_age[c] == pe - 1 && a_bu[c] > 0 && m_cnt[c] + 1 >= a_bu[c];
    end
    if (cfg_wr && int'(cfg_ch) < NCH) begin
      s_per[cfg_ch] = int'(cfg_period); s_hi[cfg_ch] = int'(cfg_high);
      s_ph[cfg_ch]  = int'(cfg_phase);  s_bu[cfg_ch] = int'(cfg_burst);
    end
  endtask

  // One clock: advance the model with the driven inputs, then compare.
  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    chk("model", {q, busy, done, led}, {e_q, e_busy, e_done, e_led});
  endtask

  task automatic rec(input int k);
    hq[k] = q; hb[k] = busy; hd[k] = done; hl[k] = led;
  endtask

  task automatic set_cfg(input int ch, input int p, input int h, input int ph, input int b);
    cfg_wr = 1'b1; cfg_ch = 3'(ch);
    cfg_period = CW'(p); cfg_high = CW'(h); cfg_phase = CW'(ph); cfg_burst = BW'(b);
  endtask

  task automatic wr(input int ch, input int p, input int h, input int ph, input int b);
    set_cfg(ch, p, h, ph, b); tick(); cfg_wr = 1'b0;
  endtask

  task automatic add(input int ch, input int k, input logic eq, input logic eb, input logic ed);
    vec_t v;
    v.ch = ch; v.k = k; v.q = eq; v.busy = eb; v.done = ed;
    tbl.push_back(v);
  endtask

  initial begin
    int nq, nd, nb, nm;
    // ch0: period 10 high 3 phase 0 continuous; ch1: period 8 high 2 phase 5 burst 3
    add(0, 1, 1, 1, 0);  add(0, 3, 1, 1, 0);  add(0, 4, 0, 1, 0);  add(0, 10, 0, 1, 0);
    add(0, 11, 1, 1, 0); add(0, 14, 0, 1, 0); add(0, 33, 1, 1, 0); add(0, 34, 0, 1, 0);
    add(1, 1, 0, 1, 0);  add(1, 5, 0, 1, 0);  add(1, 6, 1, 1, 0);  add(1, 7, 1, 1, 0);
    add(1, 8, 0, 1, 0);  add(1, 14, 1, 1, 0); add(1, 22, 1, 1, 0); add(1, 24, 0, 1, 0);
    add(1, 28, 0, 1, 0); add(1, 29, 0, 1, 1); add(1, 30, 0, 0, 0); add(1, 35, 0, 0, 0);

    rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_high = '0;
    cfg_phase = '0; cfg_burst = '0; start = '0; stop = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset outputs", {q, busy, done, led}, 32'd0);

    // Directed table: ch0 and ch1 started together.
    wr(0, 10, 3, 0, 0); wr(1, 8, 2, 5, 3);
    start = 5'b00011; tick(); rec(1); start = '0;
    for (int k = 2; k <= 40; k++) begin tick(); rec(k); end
    foreach (tbl[i])
      chk($sformatf("tbl ch%0d k%0d", tbl[i].ch, tbl[i].k),
          {hq[tbl[i].k][tbl[i].ch], hb[tbl[i].k][tbl[i].ch], hd[tbl[i].k][tbl[i].ch]},
          {tbl[i].q, tbl[i].busy, tbl[i].done});
    nq = 0; nd = 0;
    for (int k = 1; k <= 40; k++) begin nq += int'(hd[k][0]); nd += int'(hd[k][1]); end
    chk("ch0 done count", nq, 0);
    chk("ch1 done count", nd, 1);
    stop = 5'b00011; tick(); stop = '0;

    // high=0 never pulses; high>=period holds q for the whole run.
    wr(2, 10, 0, 0, 2);
    nq = 0; nd = 0; nb = 0;
    for (int k = 0; k < 25; k++) begin
      start = (k == 0) ? 5'b00100 : '0; tick();
      nq += int'(q[2]); nd += int'(done[2]); nb += int'(busy[2]);
    end
    chk("high0 q count", nq, 0); chk("high0 done", nd, 1); chk("high0 busy", nb, 20);
    wr(2, 10, 12, 0, 2);
    nm = 0; nd = 0; nb = 0;
    for (int k = 0; k < 25; k++) begin
      start = (k == 0) ? 5'b00100 : '0; tick();
      nm += int'(q[2] != busy[2]); nd += int'(done[2]); nb += int'(busy[2]);
    end
    chk("highfull q!=busy", nm, 0); chk("highfull done", nd, 1); chk("highfull busy", nb, 20);

    // Mid-period rewrite waits for the wrap; out-of-range writes are dropped.
    wr(0, 10, 3, 0, 0);
    start = 5'b00001; tick(); rec(1); start = '0;
    for (int k = 2; k <= 30; k++) begin
      if (k == 4) set_cfg(0, 4, 3, 0, 0);
      else if (k == 5) set_cfg(5, 2, 1, 0, 1);
      else if (k == 6) set_cfg(7, 2, 1, 0, 1);
      else cfg_wr = 1'b0;
      tick(); rec(k);
    end
    cfg_wr = 1'b0;
    foreach (hq[k]) if (k == 11 || k == 15 || k == 19 || k == 23 || k == 27)
      chk($sformatf("rewrite rise k%0d", k), hq[k][0] & ~hq[k-1][0], 1);
    chk("rewrite no rise k21", hq[21][0] & ~hq[20][0], 0);
    stop = 5'b00001; tick(); stop = '0;

    // start and stop together: stop wins.
    wr(3, 5, 2, 0, 0);
    start = 5'b01000; stop = 5'b01000; tick(); start = '0; stop = '0;
    chk("start+stop busy3", busy[3], 0); chk("start+stop q3", q[3], 0);
    // stop during DELAY
    start = 5'b00010; tick(); start = '0; tick();
    stop = 5'b00010; tick(); stop = '0;
    chk("stop in delay busy1", busy[1], 0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin tick(); nd += int'(done[1]); end
    chk("stop in delay done", nd, 0);
    // ch1 config untouched by the dropped writes; then reset mid-burst.
    start = 5'b00010; tick(); rec(1); start = '0;
    for (int k = 2; k <= 13; k++) begin tick(); rec(k); end
    chk("ch1 cfg intact k5", hq[5][1], 0); chk("ch1 cfg intact k6", hq[6][1], 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst mid q", q, 0); chk("rst mid busy", busy, 0); chk("rst mid done", done, 0);
    nd = 0;
    for (int k = 0; k < 5; k++) begin tick(); nd += int'(done != '0); end
    chk("rst mid no done", nd, 0);

    // LED: LED_DIV=2, period 4 -> toggles every 8 cycles.
    rst = 1'b1; tick(); rst = 1'b0;
    wr(0, 4, 1, 0, 0);
    start = 5'b00001; tick(); rec(1); start = '0;
    for (int k = 2; k <= 40; k++) begin tick(); rec(k); end
    chk("led k5", hl[5], 0);  chk("led k6", hl[6], 1);   chk("led k13", hl[13], 1);
    chk("led k14", hl[14], 0); chk("led k22", hl[22], 1); chk("led k30", hl[30], 0);
    chk("led k38", hl[38], 1);

    // Random traffic against the model.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0)
        set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      else cfg_wr = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 15) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    cfg_wr = 1'b0; start = '0; stop = '0; rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
